uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin transmit scheduler that shares one UART serial line among `NUM_REQ` byte producers. It arbitrates among the requesters and captures the winning byte. It then sequences the frame (start, data, optional parity, stop bits) at a programmable bit period and drives `tx_o`. It sits between the APB-UART transmit FIFOs/side-channel producers and the pad, and its line format matches the bench UART model: LSB first, idle high, `parity_type` 1 = odd.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `DIV_W`, 16, width of bit-period divider
- `clk_i`  in  1  clock
- `rst_ni`  in  1  synchronous, active-low reset
- `req_valid_i`  in  NUM_REQ  per-requester byte valid
- `req_data_i`  in  NUM_REQ×8  per-requester byte; slice i = bits [8i+7:8i]
- `req_ready_o`  out  NUM_REQ  one-hot acceptance strobe
- `clk_div_i`  in  DIV_W  clock cycles per bit; values below 2 are treated as 2
- `data_bits_i`  in  2  0→5, 1→6, 2→7, 3→8 data bits
- `parity_en_i`  in  1  insert parity bit
- `parity_type_i`  in  1  0 = even, 1 = odd
- `second_stop_i`  in  1  2 stop bits when 1
- `tx_o`  out  1  serial line
- `busy_o`  out  1  frame in progress
- `grant_idx_o`  out  $clog2(NUM_REQ)  index of the last/current granted requester
- `frame_done_o`  out  1  one-cycle pulse on the last cycle of the final stop bit

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE**
  - `tx_o`=1 and `busy_o`=0.
  - If any `req_valid_i` is set, pick the first valid index searching from `last+1` (wrapping).
  - That cycle: assert its `req_ready_o` bit only, capture the byte, latch all config inputs, set `grant_idx_o`, update `last`, go to START.
- **START**: `tx_o`=0 for one bit period.
- **DATA**: `tx_o`=data[k], k = 0..nbits-1, one bit period each.
- **PARITY** (only if latched parity_en): `tx_o` = XOR of active data bits, inverted when latched parity_type=1.
- **STOP1**: `tx_o`=1 for one bit period. Then go to STOP2 if latched second_stop is set, else IDLE.
- **STOP2**: `tx_o`=1 for one bit period, then IDLE.
- Bit timer:
  - Down-counter loaded with eff_div-1 on entry to each bit. The bit advances when the counter is 0.
  - eff_div = max(`clk_div_i`, 2), latched at acceptance.
- Data bits above nbits are ignored for both shifting and parity.
- Requesters keep `req_valid_i` and data stable until they see `req_ready_o`. Deasserting valid before grant is allowed (no acceptance).

## Timing
- Reset values:
  - `tx_o`=1, `req_ready_o`=0, `busy_o`=0, `grant_idx_o`=0, `frame_done_o`=0.
  - State IDLE; `last`=NUM_REQ-1, so requester 0 wins first.
- Acceptance at edge N: `tx_o` falls and `busy_o` rises at edge N+1.
- Frame length = eff_div × (1 + nbits + P + S) cycles, where P = parity_en and S = 1 + second_stop.
- `frame_done_o` is high in the last cycle of the final stop bit. IDLE follows, giving exactly one idle-high cycle between back-to-back frames.
- Config inputs changing mid-frame have no effect until the next acceptance.
- Reset asserted mid-frame:
  - Next edge: `tx_o`=1, state IDLE, byte discarded, `last` reinitialised.
  - No `frame_done_o`.
- Simultaneous valid from all requesters: exactly one ready per frame, in strict rotation.

## Configuration
- `UART_TX_SCHED_PARITY_EN` defined: PARITY state and parity logic are compiled in, behaving as above.
- Not defined:
  - `parity_en_i` and `parity_type_i` remain as ports but are ignored.
  - PARITY state is never entered and frames never carry a parity bit.

## Structure
- `uart_tx_sched_pkg`:
  - state enum `uart_tx_state_e`.
  - `data_bits_e` encoding and a function mapping encoding → bit count.
  - constant `MIN_DIV`=2.
- Sub-module `rr_arbiter`:
  - Parameterised by `NUM_REQ`.
  - Inputs: request vector, `last` pointer, enable.
  - Outputs: one-hot grant and index.
  - Purely combinational; the pointer register stays in `uart_tx_sched`.

## Test plan
- clk_div=4, 8N1, req0 sends 0x55 → `tx_o` = 0,1,0,1,0,1,0,1,0,1 at 4 cycles each; 40 cycles total; `frame_done_o` pulses at cycle 40; one idle cycle follows.
- Parity on, odd, 8 bits, byte 0x07 → parity bit 0; byte 0x03 with even parity → parity bit 0; with odd → 1. Without the macro, the same stimulus yields no parity bit (frame of 10 bits).
- All 4 requesters valid continuously with bytes 0xA0..0xA3 → grants in order 0,1,2,3,0; `req_ready_o` one-hot; serialized bytes match.
- data_bits=0 (5 bits), second_stop=1, byte 0xFF, clk_div=3 → 8 bits × 3 = 24 cycles; only 5 data ones are sent.
- clk_div=0 and clk_div=1 → bit period of 2 cycles.
- `rst_ni` low for 1 cycle at the 3rd data bit → `tx_o`=1 next edge; no `frame_done_o`; the next request from requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Frame states, data-width encoding, divider floor and parity helpers.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } uart_tx_state_e;

  typedef enum logic [1:0] {
    DB_5 = 2'd0,
    DB_6 = 2'd1,
    DB_7 = 2'd2,
    DB_8 = 2'd3
  } data_bits_e;

  localparam int MIN_DIV = 2;

  typedef struct packed {
    data_bits_e data_bits;
    logic       par_en;
    logic       par_odd;
    logic       two_stop;
  } frame_cfg_t;

  function automatic logic [3:0] data_bits_count(data_bits_e enc);
    case (enc)
      DB_5:    return 4'd5;
      DB_6:    return 4'd6;
      DB_7:    return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] data_mask(data_bits_e enc);
    case (enc)
      DB_5:    return 8'h1F;
      DB_6:    return 8'h3F;
      DB_7:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Only the active data bits contribute; odd parity inverts the XOR.
  function automatic logic calc_parity(logic [7:0] byte_val, data_bits_e enc, logic odd);
    return (^(byte_val & data_mask(enc))) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side byte handshake bundle: per-requester valid and byte in, one-hot ready back.
// The requester holds valid and data stable until it sees its ready bit.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_ready_o;

  modport master (
    output req_valid_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the last pointer, wrapping.
// Zero latency; grant is empty when disabled or when nothing requests.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;
  int   cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (en && !found && req[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        idx                    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART TX scheduler; parity bit compiled in only with UART_TX_SCHED_PARITY_EN.
// tx_o starts one cycle after acceptance; requesters are held off (ready low) for the whole frame.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  uart_tx_sched_if.slave             req,
  input  logic [DIV_W-1:0]           clk_div_i,
  input  logic [1:0]                 data_bits_i,
  input  logic                       parity_en_i,
  input  logic                       parity_type_i,
  input  logic                       second_stop_i,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       frame_done_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  uart_tx_state_e   state_q, state_d;
  frame_cfg_t       cfg_q, cfg_in;
  logic [DIV_W-1:0] div_q, cnt_q, eff_div;
  logic [7:0]       shreg_q, sel_byte;
  logic [2:0]       bit_idx_q;
  logic [3:0]       last_bit;
  logic             par_q;
  logic [IDX_W-1:0] last_q, grant_q, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [7:0]       req_bytes [NUM_REQ];
  logic             arb_en, accept, bit_end, last_data;
  logic             tx_d, busy_d, done_d;
  logic             tx_q, busy_q, done_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req.req_data_i[g*8 +: 8];
  end

  assign arb_en = rst_ni && (state_q == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req  (req.req_valid_i),
    .last (last_q),
    .en   (arb_en),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign req.req_ready_o = gnt;
  assign accept          = |gnt;
  assign sel_byte        = req_bytes[gnt_idx];
  assign eff_div         = (clk_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div_i;
  assign bit_end         = (cnt_q == '0);
  assign last_bit        = data_bits_count(cfg_q.data_bits) - 4'd1;
  assign last_data       = (bit_idx_q == last_bit[2:0]);

  always_comb begin
    cfg_in           = '0;
    cfg_in.data_bits = data_bits_e'(data_bits_i);
    cfg_in.two_stop  = second_stop_i;
`ifdef UART_TX_SCHED_PARITY_EN
    cfg_in.par_en    = parity_en_i;
    cfg_in.par_odd   = parity_type_i;
`else
    cfg_in.par_en    = 1'b0;
    cfg_in.par_odd   = 1'b0;
`endif
  end

`ifndef UART_TX_SCHED_PARITY_EN
  // Parity ports stay on the boundary so both builds share one pinout.
  logic unused_parity;
  assign unused_parity = parity_en_i ^ parity_type_i;
`endif

  always_comb begin
    state_d = state_q;
    tx_d    = 1'b1;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (bit_end && last_data) state_d = cfg_q.par_en ? PARITY : STOP1;
      end
      PARITY: begin
        tx_d = par_q;
        if (bit_end) state_d = STOP1;
      end
      STOP1: begin
        if (bit_end) begin
          if (cfg_q.two_stop) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      STOP2: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered, so they trail the state register by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      grant_q   <= '0;
      cfg_q     <= '0;
      div_q     <= DIV_W'(MIN_DIV);
      cnt_q     <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept) begin
        last_q    <= gnt_idx;
        grant_q   <= gnt_idx;
        cfg_q     <= cfg_in;
        div_q     <= eff_div;
        cnt_q     <= eff_div - DIV_W'(1);
        shreg_q   <= sel_byte;
        bit_idx_q <= '0;
        par_q     <= calc_parity(sel_byte, cfg_in.data_bits, cfg_in.par_odd);
      end else if (state_q != IDLE) begin
        if (bit_end) begin
          cnt_q <= div_q - DIV_W'(1);
          if (state_q == DATA) begin
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end else begin
          cnt_q <= cnt_q - DIV_W'(1);
        end
      end
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign grant_idx_o  = grant_q;

endmodule
